// File: rtl/pbutton_gesture.sv
// Push-button gesture classifier: turns debounced press/release events into
// short-press, long-press, double-click and auto-repeat pulses.
module pbutton_gesture #(
  parameter int CNT_W = 32
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             PB_state_active,
  input  logic             PB_state_pushed,
  input  logic             PB_state_released,
  input  logic [CNT_W-1:0] long_press_cycle,
  input  logic [CNT_W-1:0] double_click_cycle,
  input  logic [CNT_W-1:0] repeat_cycle,
  output logic             short_press,
  output logic             long_press,
  output logic             double_click,
  output logic             repeat_pulse,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_repeat;
  logic             r_busy;

  logic             w_clear;
  logic             w_short;
  logic             w_long;
  logic             w_double;
  logic             w_repeat;
  logic             w_release;
  logic [CNT_W-1:0] w_longLast;
  logic [CNT_W-1:0] w_doubleLast;
  logic [CNT_W-1:0] w_repeatLast;

  // A dropped level counts as a release even if the release pulse was missed.
  assign w_release    = PB_state_released | ~PB_state_active;
  assign w_longLast   = long_press_cycle - CNT_W'(1);
  assign w_doubleLast = double_click_cycle - CNT_W'(1);
  assign w_repeatLast = repeat_cycle - CNT_W'(1);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Branch order encodes priority: release beats long-press, push beats timeout.
  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    w_repeat = 1'b0;
    case (r_state)
      IDLE: begin
        if (PB_state_pushed) begin
          w_next  = PRESS1;
          w_clear = 1'b1;
        end
      end
      PRESS1: begin
        if (w_release) begin
          w_clear = 1'b1;
          if (double_click_cycle == '0) begin
            w_short = 1'b1;
            w_next  = IDLE;
          end else begin
            w_next = WAIT2;
          end
        end else if (long_press_cycle != '0 && r_cnt == w_longLast) begin
          w_long  = 1'b1;
          w_next  = LONG;
          w_clear = 1'b1;
        end
      end
      LONG: begin
        if (w_release) begin
          w_next  = IDLE;
          w_clear = 1'b1;
        end else if (repeat_cycle != '0 && r_cnt == w_repeatLast) begin
          w_repeat = 1'b1;
          w_clear  = 1'b1;
        end
      end
      WAIT2: begin
        if (PB_state_pushed) begin
          w_next  = PRESS2;
          w_clear = 1'b1;
        end else if (r_cnt == w_doubleLast) begin
          w_short = 1'b1;
          w_next  = IDLE;
          w_clear = 1'b1;
        end
      end
      PRESS2: begin
        if (w_release) begin
          w_double = 1'b1;
          w_next   = IDLE;
          w_clear  = 1'b1;
        end
      end
      default: begin
        w_next  = IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (r_state != IDLE && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_repeat <= w_repeat;
      r_busy   <= (w_next != IDLE);
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_click = r_double;
  assign repeat_pulse = r_repeat;
  assign busy         = r_busy;

endmodule

// File: tb/tb_pbutton_gesture.sv
// Table-driven bench for pbutton_gesture: each record is one clock edge of
// stimulus plus the outputs expected in the cycle after that edge.
module tb_pbutton_gesture;

  typedef struct {
    logic        rst;
    logic        act;
    logic        psh;
    logic        rel;
    logic [31:0] lCyc;
    logic [31:0] dCyc;
    logic [31:0] rCyc;
    logic [4:0]  exp;
  } vec_t;

  // Output vector order: {short, long, double, repeat, busy}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] B  = 5'b00001;
  localparam logic [4:0] SP = 5'b10000;
  localparam logic [4:0] LP = 5'b01001;
  localparam logic [4:0] DC = 5'b00100;
  localparam logic [4:0] RP = 5'b00011;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        pbActive = 1'b0;
  logic        pbPushed = 1'b0;
  logic        pbReleased = 1'b0;
  logic [31:0] longCycle = 32'd10;
  logic [31:0] doubleCycle = 32'd8;
  logic [31:0] repeatCycle = 32'd0;
  logic        shortPress;
  logic        longPress;
  logic        doubleClick;
  logic        repeatPulse;
  logic        busy;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];
  logic [31:0] curL = 32'd10;
  logic [31:0] curD = 32'd8;
  logic [31:0] curR = 32'd0;

  pbutton_gesture dut (
    .CLOCK_50           (CLOCK_50),
    .RESET              (RESET),
    .PB_state_active    (pbActive),
    .PB_state_pushed    (pbPushed),
    .PB_state_released  (pbReleased),
    .long_press_cycle   (longCycle),
    .double_click_cycle (doubleCycle),
    .repeat_cycle       (repeatCycle),
    .short_press        (shortPress),
    .long_press         (longPress),
    .double_click       (doubleClick),
    .repeat_pulse       (repeatPulse),
    .busy               (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic add(input logic rst, input logic act, input logic psh,
                     input logic rel, input logic [4:0] e);
    vec_t v;
    v.rst  = rst;
    v.act  = act;
    v.psh  = psh;
    v.rel  = rel;
    v.lCyc = curL;
    v.dCyc = curD;
    v.rCyc = curR;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic act, input logic [4:0] e);
    repeat (n) add(1'b0, act, 1'b0, 1'b0, e);
  endtask

  // Short press waiting out the double-click gap: push at edge 0, release at 3.
  task automatic sceneShortAfterGap();
    curL = 32'd10; curD = 32'd8; curR = 32'd0;
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(2, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, B);
    hold(7, 1'b0, B);
    add(1'b0, 1'b0, 1'b0, 1'b0, SP);
    hold(2, 1'b0, Z);
  endtask

  task automatic applyStimulus(input vec_t v);
    RESET       = v.rst;
    pbActive    = v.act;
    pbPushed    = v.psh;
    pbReleased  = v.rel;
    longCycle   = v.lCyc;
    doubleCycle = v.dCyc;
    repeatCycle = v.rCyc;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] got,
                             input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (short,long,dbl,rep,busy)",
               name, got, exp);
    end
  endtask

  initial begin
    bit seenLong;

    add(1'b1, 1'b0, 1'b0, 1'b0, Z);
    add(1'b1, 1'b0, 1'b1, 1'b0, Z);
    add(1'b0, 1'b0, 1'b0, 1'b1, Z);

    sceneShortAfterGap();

    // Long press held to edge 25 with repeat period 4.
    curL = 32'd10; curD = 32'd8; curR = 32'd4;
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(9, 1'b1, B);
    add(1'b0, 1'b1, 1'b0, 1'b0, LP);
    for (int k = 0; k < 3; k++) begin
      hold(3, 1'b1, B);
      add(1'b0, 1'b1, 1'b0, 1'b0, RP);
    end
    hold(2, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, Z);
    hold(2, 1'b0, Z);

    // Double click: push 0, release 2, push 6, release 9.
    curL = 32'd10; curD = 32'd8; curR = 32'd0;
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(1, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, B);
    hold(3, 1'b0, B);
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(2, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, DC);
    hold(2, 1'b0, Z);

    // Release on the same edge as the long-press compare: release wins.
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(9, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, B);
    hold(7, 1'b0, B);
    add(1'b0, 1'b0, 1'b0, 0, SP);
    hold(1, 1'b0, Z);

    // Push on the same edge as the gap timeout: push wins.
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, B);
    hold(7, 1'b0, B);
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, DC);
    hold(1, 1'b0, Z);

    // Gap disabled: short press right after release (pulse, then level-only).
    curD = 32'd0;
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(2, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, SP);
    hold(1, 1'b0, Z);
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    add(1'b0, 1'b0, 1'b0, 1'b0, SP);
    hold(1, 1'b0, Z);

    // Reset in LONG, then reset in WAIT2, then a fresh gesture.
    curL = 32'd10; curD = 32'd8; curR = 32'd4;
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(9, 1'b1, B);
    add(1'b0, 1'b1, 1'b0, 1'b0, LP);
    hold(1, 1'b1, B);
    add(1'b1, 1'b1, 1'b0, 1'b0, Z);
    add(1'b0, 1'b0, 1'b0, 1'b1, Z);
    hold(1, 1'b0, Z);
    add(1'b0, 1'b1, 1'b1, 1'b0, B);
    hold(1, 1'b1, B);
    add(1'b0, 1'b0, 1'b0, 1'b1, B);
    hold(2, 1'b0, B);
    add(1'b1, 1'b0, 1'b0, 1'b0, Z);
    hold(9, 1'b0, Z);
    sceneShortAfterGap();

    @(negedge CLOCK_50);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      checkOutput($sformatf("vec%0d", i),
                  {shortPress, longPress, doubleClick, repeatPulse, busy},
                  vecs[i].exp);
    end

    // Asynchronous reset while the long-press pulse is showing.
    RESET = 1'b0; longCycle = 32'd3; doubleCycle = 32'd8; repeatCycle = 32'd0;
    pbActive = 1'b1; pbPushed = 1'b1; pbReleased = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    pbPushed = 1'b0;
    seenLong = 1'b0;
    for (int n = 0; n < 10 && !seenLong; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      seenLong = longPress;
    end
    checkOutput("longSeen", {4'b0000, seenLong}, 5'b00001);
    RESET = 1'b1;
    #1;
    checkOutput("asyncReset",
                {shortPress, longPress, doubleClick, repeatPulse, busy}, Z);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    pbActive = 1'b0;
    repeat (3) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      checkOutput("postReset",
                  {shortPress, longPress, doubleClick, repeatPulse, busy}, Z);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
